// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the fifo_push_arbiter slice.
package fifo_arb_pkg;

    localparam int unsigned ARB_N_REQ_DEF = 4;
    localparam int unsigned ARB_BITS_DEF  = 16;
    localparam int unsigned ARB_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        BLOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted req after index `last` wins.
module rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!valid && req[LW'((32'(last) + k) % N)]) begin
                gnt[LW'((32'(last) + k) % N)] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push-side arbiter in front of fifo_flops, tracking occupancy incl. in-flight push.
// Optional starvation detector enabled by defining FIFO_ARB_STARVE_EN.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = ARB_N_REQ_DEF,
    parameter  int unsigned BITS       = ARB_BITS_DEF,
    parameter  int unsigned DEPTH      = ARB_DEPTH_DEF,
    parameter  int unsigned STARVE_MAX = 32,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*BITS-1:0] din_req,
    output logic [N_REQ-1:0]      gnt,
    input  logic                  fifo_pop,
    input  logic                  fifo_pndng,
    output logic                  push,
    output logic [BITS-1:0]       Din,
    output logic [CW-1:0]         count,
    output logic                  starve,
    output arb_state_t            state
);

    localparam int unsigned LW = $clog2(N_REQ);

    arb_state_t       state_d;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_valid;
    logic [LW-1:0]    last;
    logic [LW-1:0]    win_idx;
    logic [BITS-1:0]  win_data;
    logic             grant;
    logic             pop_eff;
    logic [CW-1:0]    count_d;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .last  (last),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Arbitration state is a pure function of req and occupancy.
    always_comb begin
        state_d = IDLE;
        if (req != '0) begin
            state_d = (count == CW'(DEPTH)) ? BLOCKED : ARB;
        end
    end

    assign grant   = rst && (state_d == ARB) && pick_valid;
    assign gnt     = grant ? pick_gnt : '0;
    assign pop_eff = fifo_pop && fifo_pndng;

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_gnt[i]) begin
                win_idx  = LW'(i);
                win_data = win_data | din_req[i*BITS +: BITS];
            end
        end
    end

    // Saturating occupancy; a simultaneous grant and pop cancel out.
    always_comb begin
        count_d = count;
        if (grant && !pop_eff && count != CW'(DEPTH)) begin
            count_d = count + CW'(1);
        end else if (!grant && pop_eff && count != '0) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= LW'(N_REQ - 1);
            push  <= 1'b0;
            Din   <= '0;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            push  <= grant;
            if (grant) begin
                Din  <= win_data;
                last <= win_idx;
            end
        end
    end

    // Out-of-range configurations elaborate this marker block.
    if (N_REQ < 2 || N_REQ > 8 || STARVE_MAX == 0) begin : g_param_out_of_range
    end

`ifdef FIFO_ARB_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] scnt   [N_REQ];
    logic [SW-1:0] scnt_d [N_REQ];
    logic          starve_hit;

    // Per-requester wait counters, saturating at the threshold.
    always_comb begin
        starve_hit = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            scnt_d[i] = '0;
            if (req[i] && !gnt[i]) begin
                scnt_d[i] = (scnt[i] == SW'(STARVE_MAX)) ? scnt[i] : scnt[i] + SW'(1);
            end
            if (scnt_d[i] == SW'(STARVE_MAX)) begin
                starve_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                scnt[i] <= '0;
            end
            starve <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                scnt[i] <= scnt_d[i];
            end
            if (starve_hit) begin
                starve <= 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized self-checking bench for fifo_push_arbiter against a queue-based reference model.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int N    = 4;
    localparam int B    = 16;
    localparam int D    = 16;
    localparam int SMAX = 5;
    localparam int CW   = $clog2(D + 1);
`ifdef FIFO_ARB_STARVE_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*B-1:0] din_req;
    logic [N-1:0]   gnt;
    logic           fifo_pop;
    logic           fifo_pndng;
    logic           push;
    logic [B-1:0]   Din;
    logic [CW-1:0]  count;
    logic           starve;
    arb_state_t     state;

    fifo_push_arbiter #(.N_REQ(N), .BITS(B), .DEPTH(D), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .req(req), .din_req(din_req), .gnt(gnt),
        .fifo_pop(fifo_pop), .fifo_pndng(fifo_pndng), .push(push), .Din(Din),
        .count(count), .starve(starve), .state(state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [B-1:0] hold [N];
    int           m_last;
    int           m_count;
    bit           m_push;
    logic [B-1:0] m_din;
    int           sc [N];
    bit           m_starve;
    logic [B-1:0] fifo_q [$];
    logic [B-1:0] exp_q  [$];

    task automatic model_reset();
        m_last = N - 1; m_count = 0; m_push = 0; m_din = '0; m_starve = 0;
        for (int i = 0; i < N; i++) sc[i] = 0;
        fifo_q.delete(); exp_q.delete();
    endtask

    // One clock of traffic: called at negedge with req/hold/fifo_pop set.
    task automatic step(output int win);
        logic [N-1:0] eg;
        int           w, idx;
        bit           pe, cur_push;
        logic [B-1:0] cur_din, got, want;
        fifo_pndng = (fifo_q.size() != 0);
        for (int i = 0; i < N; i++) din_req[i*B +: B] = hold[i];
        pe = fifo_pop && fifo_pndng;
        w  = -1;
        eg = '0;
        if (req != '0 && m_count < D) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        #1;
        checks++;
        if (gnt !== eg) begin failures++; $display("FAIL gnt: got %b exp %b", gnt, eg); end
        cur_push = push;
        cur_din  = Din;
        @(posedge clk);
        if (pe) begin
            got  = fifo_q.pop_front();
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (got !== want) begin failures++; $display("FAIL fifo_order: got %h exp %h", got, want); end
        end
        if (cur_push) fifo_q.push_back(cur_din);
        m_push = (w >= 0);
        if (w >= 0) begin
            m_din  = hold[w];
            m_last = w;
            exp_q.push_back(hold[w]);
        end
        m_count = m_count + ((w >= 0) ? 1 : 0) - (pe ? 1 : 0);
        if (m_count > D) m_count = D;
        if (m_count < 0) m_count = 0;
        for (int i = 0; i < N; i++) begin
            sc[i] = (req[i] && !eg[i]) ? ((sc[i] < SMAX) ? sc[i] + 1 : SMAX) : 0;
            if (sc[i] >= SMAX) m_starve = 1;
        end
        #1;
        checks += 4;
        if (push !== m_push) begin failures++; $display("FAIL push: got %b exp %b", push, m_push); end
        if (Din !== m_din) begin failures++; $display("FAIL Din: got %h exp %h", Din, m_din); end
        if (count !== CW'(m_count)) begin failures++; $display("FAIL count: got %0d exp %0d", count, m_count); end
        if (starve !== (SE & m_starve)) begin failures++; $display("FAIL starve: got %b exp %b", starve, SE & m_starve); end
        win = w;
        @(negedge clk);
    endtask

    task automatic drain();
        int w, n;
        req = '0; fifo_pop = 1'b1; n = 0;
        while ((m_count != 0 || fifo_q.size() != 0 || m_push) && n < 64) begin
            step(w); n++;
        end
        checks++;
        if (m_count != 0 || fifo_q.size() != 0) begin
            failures++; $display("FAIL drain_timeout: count %0d fifo %0d exp 0", m_count, fifo_q.size());
        end
        fifo_pop = 1'b0;
    endtask

    task automatic update_reqs(input int w);
        if (w >= 0) begin
            hold[w] = B'($urandom);
            req[w]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1) begin
                hold[i] = B'($urandom);
                req[i]  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int w;
        rst = 1'b1; req = '1; fifo_pop = 1'b0; fifo_pndng = 1'b0;
        for (int i = 0; i < N; i++) begin hold[i] = B'($urandom); din_req[i*B +: B] = hold[i]; end
        #2 rst = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            checks += 3;
            if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b exp 0", gnt); end
            if (push !== 1'b0) begin failures++; $display("FAIL reset_push: got %b exp 0", push); end
            if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d exp 0", count); end
        end
        checks += 3;
        if (Din !== '0) begin failures++; $display("FAIL reset_Din: got %h exp 0", Din); end
        if (starve !== 1'b0) begin failures++; $display("FAIL reset_starve: got %b exp 0", starve); end
        if (state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", state, IDLE); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL first_gnt: got %b exp 0001", gnt); end
        step(w);
    endtask

    task automatic test_round_robin();
        int w, prev;
        for (int i = 0; i < N; i++) hold[i] = B'(16'h00A0 + i);
        req = '1; fifo_pop = 1'b1; prev = m_last;
        for (int j = 0; j < 12; j++) begin
            step(w);
            checks += 2;
            if (w != (prev + 1) % N) begin failures++; $display("FAIL rr_order: got %0d exp %0d", w, (prev + 1) % N); end
            if (push !== 1'b1) begin failures++; $display("FAIL rr_push: got %b exp 1", push); end
            prev = w;
        end
    endtask

    task automatic test_overflow();
        int w, grants;
        drain();
        req = 4'b0100; hold[2] = B'($urandom); fifo_pop = 1'b0; grants = 0;
        for (int j = 0; j < 18; j++) begin
            step(w);
            if (w >= 0) begin grants++; hold[2] = B'($urandom); end
        end
        checks += 3;
        if (grants != 16) begin failures++; $display("FAIL ovf_grants: got %0d exp 16", grants); end
        if (count !== CW'(16)) begin failures++; $display("FAIL ovf_count: got %0d exp 16", count); end
        if (state !== BLOCKED) begin failures++; $display("FAIL ovf_state: got %0d exp %0d", state, BLOCKED); end
        fifo_pop = 1'b1;
        step(w);
        fifo_pop = 1'b0;
        checks += 2;
        if (w >= 0) begin failures++; $display("FAIL full_pop_gnt: got %0d exp none", w); end
        if (count !== CW'(15)) begin failures++; $display("FAIL pop_count: got %0d exp 15", count); end
        step(w);
        checks++;
        if (w != 2) begin failures++; $display("FAIL resume_gnt: got %0d exp 2", w); end
        req = '0;
    endtask

    task automatic test_simultaneous();
        int w;
        drain();
        req = 4'b0001; hold[0] = B'($urandom);
        while (m_count < 8) begin
            step(w);
            if (w >= 0) hold[0] = B'($urandom);
        end
        fifo_pop = 1'b1;
        step(w);
        checks++;
        if (count !== CW'(8)) begin failures++; $display("FAIL simul_count: got %0d exp 8", count); end
        update_reqs(w);
        for (int j = 0; j < 17; j++) begin
            if (req == '0) begin req[0] = 1'b1; hold[0] = B'($urandom); end
            step(w);
            update_reqs(w);
        end
        req = '0;
        drain();
    endtask

    task automatic test_underflow();
        int w;
        drain();
        req = '0; fifo_pop = 1'b1;
        repeat (20) step(w);
        checks++;
        if (count !== '0) begin failures++; $display("FAIL underflow_count: got %0d exp 0", count); end
        fifo_pop = 1'b0;
    endtask

    task automatic test_starve();
        int w, n;
        drain();
        checks++;
        if (starve !== 1'b0) begin failures++; $display("FAIL starve_pre: got %b exp 0", starve); end
        req = 4'b0100; hold[2] = B'($urandom); n = 0;
        while (m_count < D && n < 40) begin
            step(w); n++;
            if (w >= 0) hold[2] = B'($urandom);
        end
        req = 4'b0010; hold[1] = B'($urandom);
        repeat (5) step(w);
        checks++;
        if (starve !== SE) begin failures++; $display("FAIL starve_set: got %b exp %b", starve, SE); end
        drain();
        checks++;
        if (starve !== SE) begin failures++; $display("FAIL starve_sticky: got %b exp %b", starve, SE); end
    endtask

    task automatic test_reset_mid();
        int w;
        req = '1; fifo_pop = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = B'($urandom);
        repeat (3) step(w);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (push !== 1'b0) begin failures++; $display("FAIL midrst_push: got %b exp 0", push); end
        if (count !== '0) begin failures++; $display("FAIL midrst_count: got %0d exp 0", count); end
        if (gnt !== '0) begin failures++; $display("FAIL midrst_gnt: got %b exp 0", gnt); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(w);
        checks++;
        if (w != 0) begin failures++; $display("FAIL midrst_first: got %0d exp 0", w); end
    endtask

    task automatic test_random();
        int w;
        req = '0;
        update_reqs(-1);
        for (int j = 0; j < 300; j++) begin
            fifo_pop = 1'($urandom_range(0, 2) != 0);
            step(w);
            update_reqs(w);
        end
        req = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_overflow();
        test_simultaneous();
        test_underflow();
        test_starve();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, exp completion");
        $fatal(1);
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write-side arbiter sharing the push port of one `fifo_flops` instance among `N_REQ` requesters. Selects at most one requester per cycle, registers its data onto the FIFO `Din`/`push` pins, and tracks FIFO occupancy, including the in-flight push, so the FIFO never overflows. The block sits directly in front of `fifo_flops`; the consumer drives the FIFO `pop` pin, and the arbiter observes it.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `BITS`, 16, data width; must match the FIFO
- `DEPTH`, 16, FIFO depth; must match the FIFO
- `STARVE_MAX`, 32, starvation threshold in cycles (only with `FIFO_ARB_STARVE_EN`)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `req` in N_REQ: per-requester request; held with data until granted
- `din_req` in N_REQ*BITS: requester data, slice i = `din_req[i*BITS +: BITS]`
- `gnt` out N_REQ: one-hot combinational grant; data is accepted at the end of that cycle
- `fifo_pop` in 1: copy of the FIFO `pop` pin
- `fifo_pndng` in 1: FIFO `pndng` output
- `push` out 1: registered, to FIFO `push`
- `Din` out BITS: registered, to FIFO `Din`
- `count` out $clog2(DEPTH+1): occupancy including any in-flight push
- `starve` out 1: sticky starvation flag (0 when the macro is off)

## Operation
- FSM states:
  - IDLE: no `req`.
  - ARB: `req` present and `count < DEPTH`.
  - BLOCKED: `req` present and `count == DEPTH`.
- FSM state is combinationally recomputed every cycle from `req` and `count`. It is registered for observability only.
- Grant is issued only in ARB.
- Round-robin pointer `last`:
  - Search order is `last+1`, `last+2`, … modulo `N_REQ`; the first asserted `req` wins.
  - On grant, `last` is set to the winner.
  - Reset value of `last` is `N_REQ-1`, so requester 0 wins first.
- On a grant at edge e: `push` = 1 and `Din` = winner data for the cycle after e. With no grant, `push` = 0 and `Din` holds its value.
- `count` next value = `count` + grant − (`fifo_pop` & `fifo_pndng`).
  - A simultaneous grant and pop leaves `count` unchanged.
  - `count` saturates: it never exceeds `DEPTH` and never goes below 0.
- Because `count` increments on grant, it leads the FIFO's internal count by one cycle while a push is in flight.
- Full boundary: at `count == DEPTH`, no grant is issued even if `fifo_pop` is asserted in the same cycle. Grants resume the cycle after `count` drops.
- Reset mid-operation:
  - All state clears immediately and asynchronously.
  - An in-flight `push` is dropped.
  - Requesters must re-present their data.
- Requester contract: after `req` rises, `req` and the data slice stay stable until `gnt[i]`. Violations are not detected.

## Timing
- Reset values: `gnt` = 0, `push` = 0, `Din` = 0, `count` = 0, `starve` = 0, `last` = N_REQ-1, FSM = IDLE.
- Latency: `req` → `gnt` is 0 cycles when in ARB; `gnt` → `push`/`Din` is 1 cycle.
- Throughput: one push per cycle while not BLOCKED, across any mix of requesters.
- Fairness: with all `N_REQ` requesting continuously, each requester is granted exactly once in every `N_REQ` consecutive grants.
- Worst-case wait while never BLOCKED: `N_REQ-1` cycles.

## Configuration
- `FIFO_ARB_STARVE_EN` defined:
  - One counter per requester, width $clog2(STARVE_MAX+1).
  - The counter increments each cycle `req[i]` is asserted without `gnt[i]`, and clears on `gnt[i]` or when `req[i]` drops.
  - When any counter reaches `STARVE_MAX`, `starve` is set to 1 and stays set until reset.
- Not defined: no counters are generated and `starve` is tied to 0.

## Structure
- Package `fifo_arb_pkg`:
  - FSM enum `arb_state_t` {IDLE, ARB, BLOCKED}.
  - Default constants `ARB_N_REQ_DEF`, `ARB_BITS_DEF`, `ARB_DEPTH_DEF`.
- Sub-module `rr_pick`: purely combinational round-robin picker. Inputs are `req` and `last`; outputs are one-hot `gnt` and a valid bit. It is reusable for a future pop-side scheduler.
- The top level holds `count`, the output registers, the FSM register and the optional starvation counters.

## Test plan
- Reset: hold `rst` = 0 for 4 cycles with all `req` = 1 → `gnt` = 0, `push` = 0, `count` = 0. After `rst` rises, the first `gnt` is `4'b0001`.
- Round robin: all four requesters with data 0xA0..0xA3 held continuously → `gnt` sequence 1, 2, 4, 8, 1…; `Din` follows 0xA0, 0xA1, 0xA2, 0xA3 one cycle later; `push` = 1 continuously.
- Overflow guard: requester 2 pushes continuously with no pop → exactly 16 grants; `count` = 16; FSM = BLOCKED; no 17th `push`. A single `fifo_pop` with `fifo_pndng` = 1 → `count` = 15 and one more grant.
- Simultaneous: `count` = 8, grant and pop in the same cycle → `count` stays 8; FIFO `Dout` order preserved across 17 mixed push/pop pairs.
- Underflow: `fifo_pop` = 1 for 20 cycles with `fifo_pndng` = 0 and `count` = 0 → `count` stays 0.
- Starvation (macro on, `STARVE_MAX` = 5): FIFO held at full with `req[1]` = 1 for 5 cycles → `starve` = 1 and stays 1 after the FIFO drains. With the macro off, the same stimulus leaves `starve` = 0.
